// File: rtl/alu_datapath.sv
// alu_datapath: register-transfer datapath of the 8-bit sequential ALU.
// Executes the micro-operations selected by the control word each cycle on
// registers A, Q, M, R (Q[-1]) and the iteration counter, and holds the
// 16-bit result for the system bus.
//
// Ports:
//   clk        in   clock, all updates on the rising edge
//   reset      in   synchronous, active-low reset
//   c[17:0]    in   control word (multiple bits may be active together)
//   op[2:0]    in   operation code (AND/OR/XOR/ADD/SUB/MUL/DIV)
//   inbus[7:0] in   operand input bus
//   Q1,Q0,R,A7 out  status bits straight from the registers
//   count7     out  iteration counter equals 7
//   result_hi  out  upper result byte (product high / remainder)
//   result_lo  out  lower result byte (product low / quotient / logic-arith result)
module alu_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] c,
    input  logic [2:0]  op,
    input  logic [7:0]  inbus,
    output logic        Q1,
    output logic        Q0,
    output logic        R,
    output logic        A7,
    output logic        count7,
    output logic [7:0]  result_hi,
    output logic [7:0]  result_lo
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;
    localparam logic [2:0]  OP_MUL = 3'b101;

    logic [DW-1:0] r_a;
    logic [DW-1:0] r_q;
    logic [DW-1:0] r_m;
    logic          r_r;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_res_hi;
    logic [DW-1:0] r_res_lo;

    logic [DW-1:0] w_a_next;
    logic [DW-1:0] w_q_next;
    logic [DW-1:0] w_m_next;
    logic          w_r_next;
    logic [CW-1:0] w_cnt_next;
    logic [DW-1:0] w_res_hi_next;
    logic [DW-1:0] w_res_lo_next;

    logic [DW-1:0] w_q_op_m;
    logic [DW-1:0] w_a_op_m;
    logic [DW-1:0] w_a_plus_m;
    logic [DW-1:0] w_a_minus_m;
    logic [DW-1:0] w_logic;

    // c[8] is the controller's end marker; the datapath has no use for it.
    logic w_unused_c8;
    assign w_unused_c8 = c[8];

    // Arithmetic and logic candidates for the A register.
    always_comb begin
        w_q_op_m    = r_q + (c[15] ? ~r_m : r_m) + DW'(c[15]);
        w_a_op_m    = r_a + (c[4]  ? ~r_m : r_m) + DW'(c[4]);
        w_a_plus_m  = r_a + r_m;
        w_a_minus_m = r_a - r_m;
        case (op[1:0])
            2'b01:   w_logic = r_q | r_m;
            2'b10:   w_logic = r_q ^ r_m;
            default: w_logic = r_q & r_m;
        endcase
    end

    // Next-state selection; A writers are prioritised, other registers update independently.
    always_comb begin
        w_a_next      = r_a;
        w_q_next      = r_q;
        w_m_next      = r_m;
        w_r_next      = r_r;
        w_cnt_next    = r_cnt;
        w_res_hi_next = r_res_hi;
        w_res_lo_next = r_res_lo;

        if (c[0])       w_a_next = '0;
        else if (c[10]) w_a_next = '0;
        else if (c[16]) w_a_next = w_logic;
        else if (c[2])  w_a_next = w_q_op_m;
        else if (c[3])  w_a_next = w_a_op_m;
        else if (c[13]) w_a_next = w_a_plus_m;
        else if (c[14]) w_a_next = w_a_minus_m;
        else if (c[12]) w_a_next = {r_a[DW-2:0], r_q[DW-1]};
        else if (c[5])  w_a_next = {r_a[DW-1], r_a[DW-1:1]};

        // Q: shifts first, then the quotient-bit insert, with a load overriding all.
        if (c[5])       w_q_next = {r_a[0], r_q[DW-1:1]};
        else if (c[12]) w_q_next = {r_q[DW-2:0], 1'b0};
        if (c[17])      w_q_next[0] = ~r_a[DW-1];
        if (c[0])       w_q_next = inbus;

        if (c[0])       w_r_next = 1'b0;
        else if (c[5])  w_r_next = r_q[0];

        if (c[1])       w_m_next = inbus;

        if (c[0] || c[11]) w_cnt_next = '0;
        else if (c[6])     w_cnt_next = r_cnt + CW'(1);

        // Remainder correction adds M back when the partial remainder is negative.
        if (c[9]) begin
            w_res_lo_next = r_q;
            w_res_hi_next = r_a[DW-1] ? w_a_plus_m : r_a;
        end else if (c[7]) begin
            if (op == OP_MUL) begin
                w_res_hi_next = r_a;
                w_res_lo_next = r_q;
            end else begin
                w_res_hi_next = '0;
                w_res_lo_next = r_a;
            end
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a      <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_r      <= 1'b0;
            r_cnt    <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else begin
            r_a      <= w_a_next;
            r_q      <= w_q_next;
            r_m      <= w_m_next;
            r_r      <= w_r_next;
            r_cnt    <= w_cnt_next;
            r_res_hi <= w_res_hi_next;
            r_res_lo <= w_res_lo_next;
        end
    end

    assign Q1        = r_q[1];
    assign Q0        = r_q[0];
    assign R         = r_r;
    assign A7        = r_a[DW-1];
    assign count7    = (r_cnt == CW'(7));
    assign result_hi = r_res_hi;
    assign result_lo = r_res_lo;

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: directed bench for alu_datapath. The bench plays the role
// of the control unit for MUL (Booth) and DIV (non-restoring) sequences and
// checks results against hand-computed constants.
module tb_alu_datapath;

    logic        clk;
    logic        reset;
    logic [17:0] c;
    logic [2:0]  op;
    logic [7:0]  inbus;
    logic        Q1, Q0, R, A7, count7;
    logic [7:0]  result_hi, result_lo;

    int n_vec = 0;
    int n_err = 0;

    alu_datapath dut (
        .clk       (clk),
        .reset     (reset),
        .c         (c),
        .op        (op),
        .inbus     (inbus),
        .Q1        (Q1),
        .Q0        (Q0),
        .R         (R),
        .A7        (A7),
        .count7    (count7),
        .result_hi (result_hi),
        .result_lo (result_lo)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] cb(input int i);
        return 18'(1) << i;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock with control word cv and bus value d; returns #1 after the edge.
    task automatic cyc(input logic [17:0] cv, input logic [7:0] d);
        c = cv;
        inbus = d;
        @(posedge clk);
        #1;
        c = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Booth multiply; stop_iter>0 abandons the sequence at that iteration.
    task automatic run_mul(input logic [7:0] mplier, input logic [7:0] mcand, input int stop_iter);
        op = 3'b101;
        cyc(cb(0), mplier);
        cyc(cb(1), mcand);
        for (int it = 1; it <= 8; it++) begin
            if (it == stop_iter) return;
            check($sformatf("mul_count7_it%0d", it), 32'(count7), 32'(it == 8));
            case ({Q0, R})
                2'b10:   cyc(cb(3) | cb(4), 8'h00);
                2'b01:   cyc(cb(3), 8'h00);
                default: ;
            endcase
            cyc(cb(5) | cb(6), 8'h00);
        end
        cyc(cb(7), 8'h00);
    endtask

    // Non-restoring divide; add/subtract chosen from the sign before the shift.
    task automatic run_div(input logic [7:0] dividend, input logic [7:0] divisor);
        logic s;
        op = 3'b110;
        cyc(cb(0), dividend);
        cyc(cb(1) | cb(11), divisor);
        for (int it = 1; it <= 8; it++) begin
            s = A7;
            cyc(cb(12), 8'h00);
            cyc(s ? cb(13) : cb(14), 8'h00);
            cyc(cb(17) | cb(6), 8'h00);
        end
        cyc(cb(9), 8'h00);
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        c = '0;
        op = '0;
        inbus = '0;

        // Reset state
        do_reset();
        check("reset_state", 32'({result_hi, result_lo, Q1, Q0, R, A7, count7}), 32'd0);

        // ADD 7F + 02
        op = 3'b011;
        cyc(cb(0), 8'h7F);
        cyc(cb(1), 8'h02);
        cyc(cb(2), 8'h00);
        check("add_a7", 32'(A7), 32'd1);
        cyc(cb(7), 8'h00);
        check("add_lo", 32'(result_lo), 32'h81);
        check("add_hi", 32'(result_hi), 32'h00);

        // SUB 5 - 9
        op = 3'b100;
        cyc(cb(0), 8'h05);
        cyc(cb(1), 8'h09);
        cyc(cb(2) | cb(15), 8'h00);
        cyc(cb(7), 8'h00);
        check("sub_lo", 32'(result_lo), 32'hFC);
        check("sub_hi", 32'(result_hi), 32'h00);

        // Logic ops on F0 / 3C
        cyc(cb(0), 8'hF0);
        cyc(cb(1), 8'h3C);
        op = 3'b010;
        cyc(cb(16), 8'h00);
        cyc(cb(7), 8'h00);
        check("xor_lo", 32'(result_lo), 32'hCC);
        op = 3'b000;
        cyc(cb(16), 8'h00);
        cyc(cb(7), 8'h00);
        check("and_lo", 32'(result_lo), 32'h30);
        op = 3'b001;
        cyc(cb(16), 8'h00);
        cyc(cb(7), 8'h00);
        check("or_lo", 32'(result_lo), 32'hFC);

        // c[10] clears A; results hold while c[8] alone is applied
        cyc(cb(10), 8'h00);
        cyc(cb(8), 8'h00);
        check("hold_lo", 32'(result_lo), 32'hFC);
        cyc(cb(7), 8'h00);
        check("clr_lo", 32'(result_lo), 32'h00);

        // MUL -3 x 7 and 7F x 7F
        run_mul(8'hFD, 8'h07, 0);
        check("mul_m3x7", 32'({result_hi, result_lo}), 32'hFFEB);
        check("mul_cnt_wrap", 32'(count7), 32'd0);
        run_mul(8'h7F, 8'h7F, 0);
        check("mul_7fx7f", 32'({result_hi, result_lo}), 32'h3F01);

        // DIV 100 / 7, 6 / 7, divide by zero
        run_div(8'd100, 8'd7);
        check("div100_q", 32'(result_lo), 32'd14);
        check("div100_r", 32'(result_hi), 32'd2);
        run_div(8'd6, 8'd7);
        check("div6_q", 32'(result_lo), 32'd0);
        check("div6_r", 32'(result_hi), 32'd6);
        run_div(8'd9, 8'd0);
        check("div0_q", 32'(result_lo), 32'hFF);

        // Conflict: c[0] beats c[2]
        op = 3'b011;
        cyc(cb(0), 8'h80);
        cyc(cb(1), 8'h01);
        cyc(cb(2), 8'h00);
        check("cfl_pre_a7", 32'(A7), 32'd1);
        cyc(cb(0) | cb(2), 8'h55);
        check("cfl_load_status", 32'({Q1, Q0, R, A7}), 32'b0100);
        cyc(cb(7), 8'h00);
        check("cfl_load_a", 32'(result_lo), 32'h00);

        // Conflict: c[3] beats c[5] for A, R and Q still shift
        cyc(cb(0), 8'h03);
        cyc(cb(1), 8'h01);
        cyc(cb(3) | cb(5), 8'h00);
        check("cfl_shift_status", 32'({Q1, Q0, R, A7}), 32'b0110);
        cyc(cb(7), 8'h00);
        check("cfl_shift_a", 32'(result_lo), 32'h01);

        // Reset mid-MUL, then ADD 1 + 1
        run_mul(8'h7F, 8'h7F, 0);
        check("pre_reset_res", 32'({result_hi, result_lo}), 32'h3F01);
        run_mul(8'hFD, 8'h07, 4);
        do_reset();
        check("midreset_state", 32'({result_hi, result_lo, Q1, Q0, R, A7, count7}), 32'd0);
        op = 3'b011;
        cyc(cb(0), 8'h01);
        cyc(cb(1), 8'h01);
        cyc(cb(2), 8'h00);
        cyc(cb(7), 8'h00);
        check("post_reset_add", 32'({result_hi, result_lo}), 32'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
